// File: rtl/ram_pkg.sv
// Shared types for the banked RAM: sweep/run state encoding and read-during-write modes.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_bank.sv
// One single-port synchronous bank. The read register updates only on a
// requested read, so a bank keeps its last read word while others are used.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LADDR_W = 4,
    parameter int WR_MODE = WR_READ_FIRST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               we,
    input  logic               rd,
    input  logic [LADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  dout
);

    logic [DATA_W-1:0] mem [2**LADDR_W];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= din;
    end

    // Clear-sweep writes do not assert rd, so the read register is left alone.
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (rd)
            dout <= (WR_MODE == WR_WRITE_FIRST && we) ? din : mem[addr];
    end

endmodule

// File: rtl/ram_banked.sv
// Word-expanded single-port RAM built from 2**BANK_BITS banks, with a
// post-reset zeroing sweep that holds off accesses until ready.
module ram_banked
    import ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int BANK_BITS = 2,
    parameter int WR_MODE   = WR_READ_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              dout_valid,
    output logic              ready
);

    localparam int LADDR_W = ADDR_W - BANK_BITS;
    localparam int NBANK   = 2**BANK_BITS;
    localparam int SEL_W   = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam logic [LADDR_W-1:0] LAST = {LADDR_W{1'b1}};

    state_t             state;
    logic [LADDR_W-1:0] clr_addr;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   sel_q;
    logic [LADDR_W-1:0] laddr;
    logic               clearing;
    logic               access;

    logic [NBANK-1:0][DATA_W-1:0] bank_dout;

    generate
        if (BANK_BITS > 0) begin : g_sel
            assign sel = addr[ADDR_W-1 -: SEL_W];
        end else begin : g_nosel
            assign sel = '0;
        end
    endgenerate

    assign laddr    = addr[LADDR_W-1:0];
    assign clearing = !rst && (state == ST_CLEAR);
    assign access   = !rst && (state == ST_RUN) && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            ready      <= 1'b0;
            dout_valid <= 1'b0;
            sel_q      <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    dout_valid <= 1'b0;
                    if (clr_addr == LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    dout_valid <= en;
                    if (en)
                        sel_q <= sel;
                end
            endcase
        end
    end

    // All banks share address/data; the sweep drives them all at once while
    // a normal access enables only the decoded bank.
    generate
        for (genvar b = 0; b < NBANK; b++) begin : g_bank
            logic hit;
            assign hit = access && (sel == SEL_W'(b));

            ram_bank #(
                .DATA_W (DATA_W),
                .LADDR_W(LADDR_W),
                .WR_MODE(WR_MODE)
            ) u_bank (
                .clk (clk),
                .rst (rst),
                .en  (clearing || hit),
                .we  (clearing || we),
                .rd  (hit),
                .addr(clearing ? clr_addr : laddr),
                .din (clearing ? '0 : datain),
                .dout(bank_dout[b])
            );
        end
    endgenerate

    assign dataout = bank_dout[sel_q];

endmodule

// File: tb/tb_ram_banked.sv
// Directed plus randomized check of ram_banked in both write modes and a wider
// configuration against an array model of the memory.
module tb_ram_banked;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, we;
    logic [5:0] addr;
    logic [7:0] datain;
    logic [7:0] dataout0, dataout1;
    logic       dout_valid0, dout_valid1, ready0, ready1;

    logic        en2, we2;
    logic [7:0]  addr2;
    logic [15:0] datain2, dataout2;
    logic        dout_valid2, ready2;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem0 [64];
    logic [7:0] exp0, exp1;

    always #5 clk = ~clk;

    ram_banked #(.DATA_W(8), .ADDR_W(6), .BANK_BITS(2), .WR_MODE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .datain(datain),
        .dataout(dataout0), .dout_valid(dout_valid0), .ready(ready0));

    ram_banked #(.DATA_W(8), .ADDR_W(6), .BANK_BITS(2), .WR_MODE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .datain(datain),
        .dataout(dataout1), .dout_valid(dout_valid1), .ready(ready1));

    ram_banked #(.DATA_W(16), .ADDR_W(8), .BANK_BITS(3), .WR_MODE(0)) u2 (
        .clk(clk), .rst(rst), .en(en2), .we(we2), .addr(addr2), .datain(datain2),
        .dataout(dataout2), .dout_valid(dout_valid2), .ready(ready2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] pat(input logic [7:0] a);
        return {a, a ^ 8'h5C};
    endfunction

    // Model: accepted access returns old word, or new word on a write in write-first mode.
    task automatic acc(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
        logic [7:0] old;
        en = e; we = w; addr = a; datain = d;
        step();
        en = 1'b0; we = 1'b0;
        if (e) begin
            old = mem0[a];
            if (w) mem0[a] = d;
            exp0 = old;
            exp1 = w ? d : old;
        end
        chk("valid0", {31'd0, dout_valid0}, {31'd0, e});
        chk("valid1", {31'd0, dout_valid1}, {31'd0, e});
        chk("data0", {24'd0, dataout0}, {24'd0, exp0});
        chk("data1", {24'd0, dataout1}, {24'd0, exp1});
    endtask

    task automatic model_reset();
        foreach (mem0[i]) mem0[i] = 8'h00;
        exp0 = 8'h00;
        exp1 = 8'h00;
    endtask

    // Counts edges from rst falling to ready for both sizes; optionally
    // holds a write request asserted while the small RAMs are still clearing.
    task automatic sweep(input logic junk, output int n0, output int n2);
        n0 = 0; n2 = 0;
        if (junk) begin
            en = 1'b1; we = 1'b1; addr = 6'h20; datain = 8'hFF;
        end
        for (int i = 1; i <= 100; i++) begin
            step();
            if (junk && !ready0) begin
                chk("clr_valid0", {31'd0, dout_valid0}, 32'd0);
                chk("clr_valid1", {31'd0, dout_valid1}, 32'd0);
            end
            if (ready0 && n0 == 0) begin
                n0 = i;
                en = 1'b0; we = 1'b0;
            end
            if (ready2 && n2 == 0) n2 = i;
            if (n0 != 0 && n2 != 0) break;
        end
        en = 1'b0; we = 1'b0;
        model_reset();
    endtask

    initial begin
        int n0, n2;
        logic [5:0] ra;
        logic [7:0] tmp8;
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; datain = '0;
        en2 = 1'b0; we2 = 1'b0; addr2 = '0; datain2 = '0;

        step();
        chk("rst_ready0", {31'd0, ready0}, 32'd0);
        chk("rst_valid0", {31'd0, dout_valid0}, 32'd0);
        chk("rst_data0", {24'd0, dataout0}, 32'd0);
        chk("rst_ready2", {31'd0, ready2}, 32'd0);
        chk("rst_data2", {16'd0, dataout2}, 32'd0);
        rst = 1'b0;
        sweep(1'b0, n0, n2);
        chk("ready_edges0", n0, 16);
        chk("ready_edges2", n2, 32);

        // Preloaded data is wiped by the sweep; requests during it are ignored.
        acc(1'b1, 1'b1, 6'd5, 8'hAA);
        acc(1'b1, 1'b0, 6'd5, 8'h00);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_ready0", {31'd0, ready0}, 32'd0);
        chk("rst2_valid0", {31'd0, dout_valid0}, 32'd0);
        chk("rst2_data0", {24'd0, dataout0}, 32'd0);
        sweep(1'b1, n0, n2);
        chk("ready_edges0_b", n0, 16);
        acc(1'b0, 1'b0, 6'd0, 8'h00);
        acc(1'b1, 1'b0, 6'd5, 8'h00);
        acc(1'b1, 1'b0, 6'h20, 8'h00);

        // Reset while clr_addr is 9 restarts the sweep.
        rst = 1'b1; step(); rst = 1'b0;
        repeat (9) step();
        chk("mid_ready0", {31'd0, ready0}, 32'd0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_ready0", {31'd0, ready0}, 32'd0);
        sweep(1'b0, n0, n2);
        chk("mid_edges0", n0, 16);
        chk("mid_edges2", n2, 32);

        // Same local address in every bank.
        acc(1'b1, 1'b1, 6'h03, 8'h11);
        acc(1'b1, 1'b1, 6'h13, 8'h22);
        acc(1'b1, 1'b1, 6'h23, 8'h33);
        acc(1'b1, 1'b1, 6'h33, 8'h44);
        acc(1'b1, 1'b0, 6'h03, 8'h00);
        acc(1'b1, 1'b0, 6'h13, 8'h00);
        acc(1'b1, 1'b0, 6'h23, 8'h00);
        acc(1'b1, 1'b0, 6'h33, 8'h00);
        acc(1'b0, 1'b0, 6'h13, 8'h00);

        // Read-during-write in both modes.
        acc(1'b1, 1'b1, 6'h07, 8'h5A);
        acc(1'b1, 1'b1, 6'h07, 8'hC3);
        chk("rdw_mode0", {24'd0, dataout0}, 32'h5A);
        chk("rdw_mode1", {24'd0, dataout1}, 32'hC3);
        acc(1'b1, 1'b0, 6'h07, 8'h00);

        // Reset has priority over a simultaneous write.
        en = 1'b1; we = 1'b1; addr = 6'h03; datain = 8'hEE; rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0; we = 1'b0;
        chk("prio_valid0", {31'd0, dout_valid0}, 32'd0);
        chk("prio_ready0", {31'd0, ready0}, 32'd0);
        sweep(1'b0, n0, n2);
        acc(1'b1, 1'b0, 6'h03, 8'h00);

        for (int i = 0; i < 300; i++) begin
            ra = 6'($urandom_range(0, 63));
            tmp8 = 8'($urandom);
            acc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, tmp8);
        end

        // Wide configuration: fill every word, then read back.
        for (int a = 0; a < 256; a++) begin
            en2 = 1'b1; we2 = 1'b1; addr2 = 8'(a); datain2 = pat(8'(a));
            step();
        end
        en2 = 1'b0; we2 = 1'b0;
        step();
        chk("w2_idle_valid", {31'd0, dout_valid2}, 32'd0);
        for (int a = 0; a < 256; a++) begin
            en2 = 1'b1; we2 = 1'b0; addr2 = 8'(255 - a);
            step();
            chk("w2_valid", {31'd0, dout_valid2}, 32'd1);
            chk("w2_data", {16'd0, dataout2}, {16'd0, pat(8'(255 - a))});
        end
        en2 = 1'b0;
        step();
        chk("w2_hold", {16'd0, dataout2}, {16'd0, pat(8'd0)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_banked.md
# ram_banked

Parametrised, word-expanded single-port synchronous RAM. It is the generalised successor to the fixed 64x8 banked RAM. Storage is split into `2**BANK_BITS` banks selected by the upper address bits, and adds what the fixed part lacks: a synchronous reset with a hardware memory-clear sweep, a `ready` flag, a selectable read-during-write mode, and a read-valid strobe. It sits between the datapath and register-level logic wherever a small on-chip scratch memory is needed.

## Interface
Parameters:
- `DATA_W`, 8, word width in bits (≥1)
- `ADDR_W`, 6, total address width; total depth = `2**ADDR_W`
- `BANK_BITS`, 2, number of upper address bits used for bank select; banks = `2**BANK_BITS`; requires `0 ≤ BANK_BITS < ADDR_W`
- `WR_MODE`, 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `en`  in  1  access request, honoured only while `ready`=1
- `we`  in  1  write enable, qualified by `en`
- `addr`  in  `ADDR_W`  word address; `addr[ADDR_W-1 -: BANK_BITS]` selects the bank, the low bits are the local address
- `datain`  in  `DATA_W`  write data
- `dataout`  out  `DATA_W`  registered read data; holds its value between reads
- `dout_valid`  out  1  one-cycle pulse: `dataout` was updated by the access accepted on the previous edge
- `ready`  out  1  high once the clear sweep is done; access allowed

## Operation
- Local depth `LDEPTH = 2**(ADDR_W-BANK_BITS)`.
- FSM states:
  - CLEAR: a local-address counter `clr_addr` writes all-zero words to every bank in parallel.
  - RUN: normal accesses.
- Transitions:
  - `rst`=1 → CLEAR, with `clr_addr`=0.
  - CLEAR with `clr_addr==LDEPTH-1` → RUN.
  - RUN holds until `rst`.
- In CLEAR: `en`/`we` are ignored, no read is performed, `dout_valid`=0, `dataout` holds.
- Accepted access in RUN (`en`=1): only the selected bank is enabled (one-hot decode ANDed with `en`).
  - Write (`we`=1): stores `datain` at the local address.
  - Every accepted access, read or write, updates `dataout` and pulses `dout_valid`.
  - On a write, `dataout` = old content when `WR_MODE`=0, `datain` when `WR_MODE`=1.
- Read data is muxed by a bank-select register captured with the access. The output therefore never depends on the combinational `addr` after the edge.
- `en`=0 in RUN: no state change; `dataout` holds; `dout_valid`=0.

## Timing
- Reset values, at the first edge with `rst`=1: `dataout`=0, `dout_valid`=0, `ready`=0, state=CLEAR, `clr_addr`=0.
- Memory contents are not touched by `rst` itself; they are zeroed only by the sweep.
- Clear sweep:
  - Runs on `LDEPTH` consecutive edges after `rst` falls, clearing local addresses 0..`LDEPTH-1`.
  - `ready` rises on the `LDEPTH`-th edge after `rst` deasserts (16 with defaults).
- Read latency is 1. For an access presented with `en`=1 before edge N, `dataout`/`dout_valid` are valid after edge N.
- Back-to-back accesses are allowed every cycle, at full throughput.
- `rst` asserted mid-sweep or mid-operation: the sweep restarts from 0 and `ready` drops on that edge.
- `rst` has priority over any simultaneous `en`/`we`; that access is dropped.
- Width rules: no arithmetic on data; `clr_addr` is `ADDR_W-BANK_BITS` bits wide and does not wrap past `LDEPTH-1`.

## Structure
- Shared package `ram_pkg`:
  - FSM state encoding (`ST_CLEAR`, `ST_RUN`)
  - `WR_MODE` constants (`WR_READ_FIRST`=0, `WR_WRITE_FIRST`=1)
- Sub-module `ram_bank` (params `DATA_W`, `LADDR_W`, `WR_MODE`):
  - one bank, single-port, synchronous, with `en` and `we`
  - instantiated `2**BANK_BITS` times in a generate loop
  - clear writes enter through the same port via a top-level mux
- Top level holds the FSM, `clr_addr`, bank decode, bank-select register and output mux.

## Test plan
- Reset and clear: preload addr 5 = 8'hAA, pulse `rst`.
  - `ready`=0 for 16 edges, then 1.
  - A read of addr 5 returns 8'h00 with `dout_valid`=1 one cycle later.
- Bank isolation: write 8'h11 to addr 0x03, 8'h22 to 0x13, 8'h33 to 0x23, 8'h44 to 0x33.
  - Reads return each value unchanged.
- Read-during-write: addr 0x07 holds 8'h5A; write 8'hC3 to it.
  - `WR_MODE`=0: `dataout`=8'h5A.
  - `WR_MODE`=1: `dataout`=8'hC3.
  - A following read returns 8'hC3 in both modes.
- Ignored access during clear: `en`=1, `we`=1, addr 0x20, data 8'hFF asserted during the sweep.
  - `dout_valid` stays 0.
  - After `ready`, addr 0x20 reads 8'h00.
- Reset mid-sweep: assert `rst` when `clr_addr`=9.
  - `ready` rises exactly 16 edges after the second `rst` falls.
- Parameter sweep: `DATA_W`=16, `ADDR_W`=8, `BANK_BITS`=3.
  - Write address-derived patterns to all 256 words, read them back, no mismatch.
  - `ready` rises after 32 edges.
